// File: rtl/blink_rate_detector_if.sv
// Signal bundle for the blink-rate detector. The detector is the master: it
// samples i_Signal and drives the measurement results.
interface blink_rate_detector_if;
    logic        i_Signal;
    logic [31:0] o_Period;
    logic        o_Valid;
    logic [2:0]  o_Rate;
    logic        o_Locked;
    logic        o_Timeout;

    modport master (
        input  i_Signal,
        output o_Period, o_Valid, o_Rate, o_Locked, o_Timeout
    );

    modport slave (
        output i_Signal,
        input  o_Period, o_Valid, o_Rate, o_Locked, o_Timeout
    );
endinterface

// File: rtl/blink_rate_detector.sv
// Measures the interval between toggles of an asynchronous square wave and
// classifies it as one of the LED blink rates, with lock and timeout flags.
module blink_rate_detector #(
    parameter int unsigned g_COUNT_10HZ = 1250000,
    parameter int unsigned g_COUNT_5HZ  = 2500000,
    parameter int unsigned g_COUNT_2HZ  = 6250000,
    parameter int unsigned g_COUNT_1HZ  = 12500000,
    parameter int unsigned g_TOL_SHIFT  = 4,
    parameter int unsigned g_TIMEOUT    = 30000000
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    blink_rate_detector_if.master bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MEAS = 1'b1;

    localparam logic [32:0] E10 = 33'(g_COUNT_10HZ) + 33'd1;
    localparam logic [32:0] E5  = 33'(g_COUNT_5HZ)  + 33'd1;
    localparam logic [32:0] E2  = 33'(g_COUNT_2HZ)  + 33'd1;
    localparam logic [32:0] E1  = 33'(g_COUNT_1HZ)  + 33'd1;
    localparam logic [32:0] T10 = E10 >> g_TOL_SHIFT;
    localparam logic [32:0] T5  = E5  >> g_TOL_SHIFT;
    localparam logic [32:0] T2  = E2  >> g_TOL_SHIFT;
    localparam logic [32:0] T1  = E1  >> g_TOL_SHIFT;
    localparam logic [31:0] TO_LAST = 32'(g_TIMEOUT - 1);

    // T never exceeds E, so E-T cannot underflow; 33 bits keep E+T from wrapping.
    function automatic logic in_win(input logic [32:0] m, input logic [32:0] e,
                                    input logic [32:0] t);
        return (m >= e - t) && (m <= e + t);
    endfunction

    function automatic logic [2:0] classify(input logic [32:0] m);
        if      (in_win(m, E10, T10)) return 3'd1;
        else if (in_win(m, E5,  T5))  return 3'd2;
        else if (in_win(m, E2,  T2))  return 3'd3;
        else if (in_win(m, E1,  T1))  return 3'd4;
        else                          return 3'd0;
    endfunction

    logic        sync1_q, sync2_q, sync3_q;
    logic [0:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period_q, period_d;
    logic        valid_q, valid_d;
    logic [2:0]  rate_q, rate_d;
    logic        locked_q, locked_d;
    logic        timeout_q, timeout_d;
    logic [2:0]  prev_q, prev_d;

    logic        edge_det;
    logic [32:0] meas;
    logic [2:0]  cls;

    assign edge_det = sync2_q ^ sync3_q;
    assign meas     = {1'b0, cnt_q} + 33'd1;
    assign cls      = classify(meas);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        rate_d    = rate_q;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        prev_d    = prev_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // First edge only provides the reference point.
                if (edge_det) begin
                    state_d   = S_MEAS;
                    timeout_d = 1'b0;
                end
            end
            S_MEAS: begin
                if (edge_det) begin
                    period_d = meas[31:0];
                    rate_d   = cls;
                    valid_d  = 1'b1;
                    cnt_d    = '0;
                    locked_d = (cls == prev_q) && (cls != 3'd0);
                    prev_d   = cls;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                    rate_d    = 3'd0;
                    locked_d  = 1'b0;
                    prev_d    = 3'd0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            rate_q    <= 3'd0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            prev_q    <= 3'd0;
        end else begin
            sync1_q   <= bus.i_Signal;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            rate_q    <= rate_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
            prev_q    <= prev_d;
        end
    end

    assign bus.o_Period  = period_q;
    assign bus.o_Valid   = valid_q;
    assign bus.o_Rate    = rate_q;
    assign bus.o_Locked  = locked_q;
    assign bus.o_Timeout = timeout_q;
endmodule

// File: tb/tb_blink_rate_detector.sv
// Directed bench for blink_rate_detector with small terminal counts so each
// rate class, the tolerance window, timeout and reset are reachable quickly.
module tb_blink_rate_detector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   step_id = 0;

    blink_rate_detector_if bif ();

    blink_rate_detector #(
        .g_COUNT_10HZ(9),
        .g_COUNT_5HZ (19),
        .g_COUNT_2HZ (49),
        .g_COUNT_1HZ (99),
        .g_TOL_SHIFT (3),
        .g_TIMEOUT   (400)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .bus  (bif.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] per, input logic vld,
                            input logic [2:0] rate, input logic lck, input logic to);
        chk({tag, ".valid"},   32'(bif.o_Valid),   32'(vld));
        chk({tag, ".period"},  bif.o_Period,        per);
        chk({tag, ".rate"},    32'(bif.o_Rate),    32'(rate));
        chk({tag, ".locked"},  32'(bif.o_Locked),  32'(lck));
        chk({tag, ".timeout"}, 32'(bif.o_Timeout), 32'(to));
    endtask

    // Interval 'gap' clocks since the previous toggle, then toggle. The level
    // change is sampled at the next posedge k; the result must appear only
    // after posedge k+2, i.e. at the third negedge following the toggle.
    task automatic step(input int gap, input logic vld, input logic [31:0] per,
                        input logic [2:0] rate, input logic lck, input logic to);
        string tag;
        step_id++;
        tag = $sformatf("step%0d", step_id);
        repeat (gap - 3) @(negedge clk);
        bif.i_Signal = ~bif.i_Signal;
        @(negedge clk);
        chk({tag, ".lat1"}, 32'(bif.o_Valid), 32'd0);
        @(negedge clk);
        chk({tag, ".lat2"}, 32'(bif.o_Valid), 32'd0);
        @(negedge clk);
        chk_outs(tag, per, vld, rate, lck, to);
    endtask

    initial begin
        bif.i_Signal = 1'b0;
        repeat (2) @(negedge clk);
        chk_outs("reset", 32'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 10 Hz: arm, then three intervals of 10
        step(10, 1'b0,  32'd0, 3'd0, 1'b0, 1'b0);
        step(10, 1'b1, 32'd10, 3'd1, 1'b0, 1'b0);
        step(10, 1'b1, 32'd10, 3'd1, 1'b1, 1'b0);
        step(10, 1'b1, 32'd10, 3'd1, 1'b1, 1'b0);

        // 5 Hz then 1 Hz
        step(20,  1'b1,  32'd20, 3'd2, 1'b0, 1'b0);
        step(20,  1'b1,  32'd20, 3'd2, 1'b1, 1'b0);
        step(100, 1'b1, 32'd100, 3'd4, 1'b0, 1'b0);
        step(100, 1'b1, 32'd100, 3'd4, 1'b1, 1'b0);

        // 5 Hz tolerance window 18..22
        step(18, 1'b1, 32'd18, 3'd2, 1'b0, 1'b0);
        step(22, 1'b1, 32'd22, 3'd2, 1'b1, 1'b0);
        step(17, 1'b1, 32'd17, 3'd0, 1'b0, 1'b0);
        step(23, 1'b1, 32'd23, 3'd0, 1'b0, 1'b0);

        // Unclassifiable interval
        step(14, 1'b1, 32'd14, 3'd0, 1'b0, 1'b0);
        step(14, 1'b1, 32'd14, 3'd0, 1'b0, 1'b0);

        // Lock at 10 Hz, then hold the input for a timeout
        step(10, 1'b1, 32'd10, 3'd1, 1'b0, 1'b0);
        step(10, 1'b1, 32'd10, 3'd1, 1'b1, 1'b0);
        repeat (399) @(negedge clk);
        chk_outs("pre_timeout", 32'd10, 1'b0, 3'd1, 1'b1, 1'b0);
        @(negedge clk);
        chk_outs("timeout", 32'd10, 1'b0, 3'd0, 1'b0, 1'b1);
        step(50, 1'b0, 32'd10, 3'd0, 1'b0, 1'b0);
        step(10, 1'b1, 32'd10, 3'd1, 1'b0, 1'b0);
        step(10, 1'b1, 32'd10, 3'd1, 1'b1, 1'b0);

        // Asynchronous reset mid-interval while locked
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        bif.i_Signal = 1'b0;
        #1;
        chk_outs("async_rst", 32'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(10, 1'b0,  32'd0, 3'd0, 1'b0, 1'b0);
        step(10, 1'b1, 32'd10, 3'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
